transmitter_fsm: RTL and testbench
==================================

TRANSMITTER_FSM -- requirements
Module: transmitter_fsm

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115_200, serial bit rate in bit/s.
REQ-003 Parameter DATA_BITS, 8, data bits per frame (legal 5..9).
REQ-004 Port sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-high (name kept for codebase consistency; 1 = reset).
REQ-006 Port tx_enable  input  1  transmit request, sampled only on baud ticks.
REQ-007 Port baud_tick  output  1  one-sys_clk-cycle strobe, once per bit period.
REQ-008 Port busy  output  1  high while a frame is in LOAD or SHIFT.
REQ-009 Port load  output  1  high for the whole LOAD bit period; the consumer loads its shift register on the baud tick ending it.
REQ-010 Port shift  output  1  high for every SHIFT bit period; the consumer shifts on each baud tick within it.

Function
REQ-011 Divider DIV SHALL be (CLK_FREQ + BAUD/2) / BAUD, integer; 434 at the defaults.
REQ-012 Baud counter SHALL be clog2(DIV) bits wide, count 0..DIV-1 and wrap to 0.
REQ-013 baud_tick SHALL be high exactly in cycles where the counter equals DIV-1: the first tick is the DIV-th cycle after reset release, then one tick every DIV cycles.
REQ-014 FSM states SHALL be IDLE, LOAD and SHIFT; state and bit counter change only on sys_clk edges where baud_tick=1.
REQ-015 Outputs SHALL be Moore and registered: IDLE busy=0 load=0 shift=0; LOAD busy=1 load=1 shift=0; SHIFT busy=1 load=0 shift=1.
REQ-016 IDLE->LOAD on a tick with tx_enable=1; with tx_enable=0 the FSM stays in IDLE.
REQ-017 LOAD->SHIFT on the next tick; the bit counter SHALL be cleared to 0.
REQ-018 SHIFT SHALL last exactly N_SHIFT ticks, N_SHIFT = DATA_BITS+2 (start+data+stop; 10 at defaults); the counter increments each tick, and on the tick where counter = N_SHIFT-1 the FSM returns to IDLE.
REQ-019 After SHIFT the FSM SHALL always spend at least one bit period in IDLE; a held tx_enable re-enters LOAD on the following tick.
REQ-020 Deassertion of tx_enable during LOAD/SHIFT SHALL NOT abort the frame; tx_enable pulses falling entirely between ticks SHALL be ignored.
REQ-021 No illegal state SHALL be reachable; unused encodings SHALL decode to IDLE.

Reset
REQ-022 While rst_n=1 at a sys_clk edge: baud counter=0, state=IDLE, bit counter=0, and baud_tick, busy, load and shift = 0 after that edge.
REQ-023 Reset mid-frame SHALL abort immediately with no partial-frame outputs afterwards; baud phase restarts from 0.

Configuration
REQ-024 Macro TRANSMITTER_FSM_PARITY_EN defined: N_SHIFT = DATA_BITS+3 (one parity bit period; 11 at defaults); undefined: N_SHIFT = DATA_BITS+2; nothing else changes.

Verification (bench params CLK_FREQ=1_000_000, BAUD=100_000 -> DIV=10; DATA_BITS=8)
REQ-025 Reset 3 cycles, release, tx_enable=0 -> baud_tick high in cycles 10, 20, 30...; busy, load and shift stay 0.
REQ-026 tx_enable=1 held from reset release -> at tick 1 LOAD (busy=1, load=1) for 10 cycles, then shift=1 for 100 cycles (10 ticks), then IDLE (busy=0) for 10 cycles, then LOAD again; repeat 3 frames.
REQ-027 One-cycle tx_enable pulse not coincident with a tick -> no frame starts; a pulse coincident with a tick -> exactly one frame.
REQ-028 tx_enable dropped in the 3rd SHIFT bit -> frame completes with the full 10 shift ticks, then IDLE, no new LOAD.
REQ-029 rst_n=1 for one cycle during SHIFT bit 5 -> all outputs 0 on the next edge; the next tick arrives 10 cycles after release.
REQ-030 Rebuild with TRANSMITTER_FSM_PARITY_EN -> shift high for 110 cycles per frame; all else identical.

Source files
------------

// File: rtl/transmitter_fsm.sv
// Baud-rate generator plus IDLE/LOAD/SHIFT frame sequencer for a serial transmitter.
// Define TRANSMITTER_FSM_PARITY_EN to add one parity bit period to every frame.
module transmitter_fsm #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic tx_enable,
    output logic baud_tick,
    output logic busy,
    output logic load,
    output logic shift
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef TRANSMITTER_FSM_PARITY_EN
    localparam int N_SHIFT = DATA_BITS + 3;
`else
    localparam int N_SHIFT = DATA_BITS + 2;
`endif
    localparam int BIT_W = $clog2(N_SHIFT);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_SHIFT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    logic [CNT_W-1:0] baud_cnt_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [BIT_W-1:0] bit_cnt_next;
    state_t           state_reg;
    state_t           state_next;
    logic             busy_reg;
    logic             load_reg;
    logic             shift_reg;

    // Free-running bit-period counter; the wrap cycle is the tick.
    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            baud_cnt_reg <= '0;
        end else if (baud_cnt_reg == DIV_LAST) begin
            baud_cnt_reg <= '0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
        end
    end

    assign baud_tick = (baud_cnt_reg == DIV_LAST);

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (baud_tick && tx_enable) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (baud_tick) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                end
            end
            SHIFT: begin
                if (baud_tick) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            load_reg    <= 1'b0;
            shift_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            busy_reg    <= (state_next == LOAD) || (state_next == SHIFT);
            load_reg    <= (state_next == LOAD);
            shift_reg   <= (state_next == SHIFT);
        end
    end

    assign busy  = busy_reg;
    assign load  = load_reg;
    assign shift = shift_reg;

endmodule

// File: tb/tb_transmitter_fsm.sv
// Scoreboard bench for transmitter_fsm: a frame-level model predicts every cycle's
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_transmitter_fsm;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD      = 100_000;
    localparam int DATA_BITS = 8;
    localparam int DIV       = 10;
`ifdef TRANSMITTER_FSM_PARITY_EN
    localparam int N_SHIFT = DATA_BITS + 3;
`else
    localparam int N_SHIFT = DATA_BITS + 2;
`endif

    logic sys_clk;
    logic rst_n;
    logic tx_enable;
    logic baud_tick;
    logic busy;
    logic load;
    logic shift;

    transmitter_fsm #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .tx_enable(tx_enable),
        .baud_tick(baud_tick),
        .busy     (busy),
        .load     (load),
        .shift    (shift)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Model: k = edges since reset release; remaining = bit periods left in frame
    // (N_SHIFT+1 = LOAD period, N_SHIFT..1 = SHIFT periods, 0 = idle).
    int k         = 0;
    int remaining = 0;
    int frames    = 0;
    int cyc       = 0;

    logic [3:0] exp_q[$];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_bound(input string name, input int guard, input int limit);
        checks++;
        if (guard >= limit) begin
            errors++;
            $display("FAIL %s: waited %0d cycles, limit %0d", name, guard, limit);
        end
    endtask

    function automatic logic tick_now();
        return (k % DIV) == (DIV - 1);
    endfunction

    task automatic step(input logic r, input logic e);
        logic [3:0] exp;
        rst_n     = r;
        tx_enable = e;
        if (r) begin
            k         = 0;
            remaining = 0;
        end else begin
            if (tick_now()) begin
                if (remaining > 0) begin
                    remaining--;
                end else if (e) begin
                    remaining = N_SHIFT + 1;
                    frames++;
                    $display("frame %0d: LOAD expected after cycle %0d", frames, cyc);
                end
            end
            k++;
        end
        exp = {tick_now(), remaining > 0, remaining == N_SHIFT + 1,
               (remaining > 0) && (remaining <= N_SHIFT)};
        exp_q.push_back(exp);
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    // Monitor: compares every presented output cycle; also measures shift runs.
    int   shift_run   = 0;
    logic run_aborted = 1'b0;

    always @(negedge sys_clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check_bit("baud_tick", baud_tick, e[3]);
            check_bit("busy",      busy,      e[2]);
            check_bit("load",      load,      e[1]);
            check_bit("shift",     shift,     e[0]);
            if (rst_n) run_aborted = 1'b1;
            if (shift === 1'b1) begin
                shift_run++;
            end else begin
                if (shift_run > 0 && !run_aborted) begin
                    checks++;
                    if (shift_run != N_SHIFT * DIV) begin
                        errors++;
                        $display("FAIL shift_len cycle %0d: got %0d expected %0d",
                                 cyc, shift_run, N_SHIFT * DIV);
                    end
                end
                shift_run   = 0;
                run_aborted = 1'b0;
            end
        end
    end

    initial begin
        int   guard;
        logic en;
        logic pulse;
        logic r;
        rst_n     = 1'b1;
        tx_enable = 1'b0;

        // Idle: ticks only, no frame activity.
        repeat (3) step(1'b1, 1'b0);
        repeat (45) step(1'b0, 1'b0);

        // Held enable: three back-to-back frames, then drain.
        repeat (3) step(1'b1, 1'b0);
        repeat (3 * (N_SHIFT + 2) * DIV) step(1'b0, 1'b1);
        repeat ((N_SHIFT + 3) * DIV) step(1'b0, 1'b0);

        // One-cycle pulse away from a tick must be ignored.
        guard = 0;
        while (tick_now() && guard < 50) begin step(1'b0, 1'b0); guard++; end
        check_bound("pulse_off_tick_wait", guard, 50);
        step(1'b0, 1'b1);
        repeat (3 * DIV) step(1'b0, 1'b0);

        // One-cycle pulse on a tick starts exactly one frame.
        guard = 0;
        while (!tick_now() && guard < 50) begin step(1'b0, 1'b0); guard++; end
        check_bound("pulse_on_tick_wait", guard, 50);
        step(1'b0, 1'b1);
        repeat ((N_SHIFT + 4) * DIV) step(1'b0, 1'b0);

        // Enable dropped during the 3rd shift bit: frame still completes.
        guard = 0;
        while (remaining != N_SHIFT - 2 && guard < 1000) begin step(1'b0, 1'b1); guard++; end
        check_bound("reach_shift_bit3", guard, 1000);
        repeat (3) step(1'b0, 1'b1);
        repeat ((N_SHIFT + 4) * DIV) step(1'b0, 1'b0);

        // Reset pulse in the 5th shift bit aborts the frame and restarts the baud phase.
        guard = 0;
        while (remaining != N_SHIFT - 4 && guard < 1000) begin step(1'b0, 1'b1); guard++; end
        check_bound("reach_shift_bit5", guard, 1000);
        repeat (4) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (4 * DIV) step(1'b0, 1'b0);

        // Randomized enable levels, stray pulses and rare resets.
        en = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            pulse = ($urandom_range(0, 49) == 0);
            r     = ($urandom_range(0, 699) == 0);
            step(r, en | pulse);
        end
        step(1'b0, 1'b0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin @(negedge sys_clk); guard++; end
        #1;
        check_bound("scoreboard_drain", guard, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
